video_timing: RTL

Parametrised, runtime-reprogrammable video timing generator; successor to the fixed 720p timing controller. Produces the pixel coordinate, sync, data-enable, frame/line strobes, a programmable line-compare interrupt and a frame counter, all registered and mutually aligned. Sits in the pixel clock domain and feeds the display pipeline and the scan-out/sprite engines.

---
 rtl/video_timing.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/video_timing.sv
// Runtime-reprogrammable video timing generator: pixel/line counters, syncs, DE, strobes.
// Define VIDEO_TIMING_RUNTIME_EN to enable the cfg_* shadow registers; otherwise timing is fixed.
module video_timing #(
    parameter int unsigned CORDW  = 11,
    parameter int unsigned FRAMEW = 16,
    parameter int unsigned HA_END = 1279,
    parameter int unsigned HS_STA = 1287,
    parameter int unsigned HS_END = 1319,
    parameter int unsigned LINE   = 1359,
    parameter int unsigned VA_END = 719,
    parameter int unsigned VS_STA = 726,
    parameter int unsigned VS_END = 734,
    parameter int unsigned SCREEN = 740,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic [CORDW-1:0]  cfg_ha_end,
    input  logic [CORDW-1:0]  cfg_hs_sta,
    input  logic [CORDW-1:0]  cfg_hs_end,
    input  logic [CORDW-1:0]  cfg_line,
    input  logic [CORDW-1:0]  cfg_va_end,
    input  logic [CORDW-1:0]  cfg_vs_sta,
    input  logic [CORDW-1:0]  cfg_vs_end,
    input  logic [CORDW-1:0]  cfg_screen,
    input  logic              cfg_hs_pol,
    input  logic              cfg_vs_pol,
    input  logic              cfg_load,
    output logic              cfg_busy,
    input  logic [CORDW-1:0]  irq_line,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start,
    output logic              line_start,
    output logic              line_irq,
    output logic [FRAMEW-1:0] frame_cnt
);

    typedef struct packed {
        logic [CORDW-1:0] ha_end;
        logic [CORDW-1:0] hs_sta;
        logic [CORDW-1:0] hs_end;
        logic [CORDW-1:0] line;
        logic [CORDW-1:0] va_end;
        logic [CORDW-1:0] vs_sta;
        logic [CORDW-1:0] vs_end;
        logic [CORDW-1:0] screen;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    localparam timing_t DEFAULTS = '{
        ha_end: CORDW'(HA_END),
        hs_sta: CORDW'(HS_STA),
        hs_end: CORDW'(HS_END),
        line:   CORDW'(LINE),
        va_end: CORDW'(VA_END),
        vs_sta: CORDW'(VS_STA),
        vs_end: CORDW'(VS_END),
        screen: CORDW'(SCREEN),
        hs_pol: HS_POL,
        vs_pol: VS_POL
    };

    timing_t          w_act;
    timing_t          w_nxt;
    logic             w_last_x;
    logic             w_last_y;
    logic             w_frame_next;
    logic [CORDW-1:0] w_nx;
    logic [CORDW-1:0] w_ny;

    logic [CORDW-1:0]  r_sx;
    logic [CORDW-1:0]  r_sy;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_de;
    logic              r_frame_start;
    logic              r_line_start;
    logic              r_line_irq;
    logic [FRAMEW-1:0] r_frame_cnt;
    logic              r_started;

`ifdef VIDEO_TIMING_RUNTIME_EN
    timing_t r_pend;
    timing_t r_act;
    timing_t w_cfg;
    logic    r_busy;

    assign w_cfg = '{
        ha_end: cfg_ha_end, hs_sta: cfg_hs_sta, hs_end: cfg_hs_end, line: cfg_line,
        va_end: cfg_va_end, vs_sta: cfg_vs_sta, vs_end: cfg_vs_end, screen: cfg_screen,
        hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol
    };

    // A load coincident with the frame wrap still applies the older pending set first.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_pend <= DEFAULTS;
            r_act  <= DEFAULTS;
            r_busy <= 1'b0;
        end else begin
            if (w_frame_next && r_busy) begin
                r_act <= r_pend;
            end
            if (cfg_load) begin
                r_pend <= w_cfg;
                r_busy <= 1'b1;
            end else if (w_frame_next) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_act    = r_act;
    assign w_nxt    = (w_frame_next && r_busy) ? r_pend : r_act;
    assign cfg_busy = r_busy;
`else
    logic w_unused;

    assign w_unused = ^{cfg_ha_end, cfg_hs_sta, cfg_hs_end, cfg_line, cfg_va_end, cfg_vs_sta,
                        cfg_vs_end, cfg_screen, cfg_hs_pol, cfg_vs_pol, cfg_load};
    assign w_act    = DEFAULTS;
    assign w_nxt    = DEFAULTS;
    assign cfg_busy = 1'b0;
`endif

    // Wrap uses the current set; decode of the next pixel uses the set that will govern it.
    always_comb begin
        w_last_x     = (r_sx == w_act.line);
        w_last_y     = (r_sy == w_act.screen);
        w_frame_next = w_last_x && w_last_y;
        w_nx         = w_last_x ? '0 : r_sx + CORDW'(1);
        w_ny         = r_sy;
        if (w_last_x) begin
            w_ny = w_last_y ? '0 : r_sy + CORDW'(1);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_sx          <= DEFAULTS.line;
            r_sy          <= DEFAULTS.screen;
            r_hsync       <= ~DEFAULTS.hs_pol;
            r_vsync       <= ~DEFAULTS.vs_pol;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_line_irq    <= 1'b0;
            r_frame_cnt   <= '0;
            r_started     <= 1'b0;
        end else begin
            r_sx          <= w_nx;
            r_sy          <= w_ny;
            r_de          <= (w_nx <= w_nxt.ha_end) && (w_ny <= w_nxt.va_end);
            r_hsync       <= ((w_nx >= w_nxt.hs_sta) && (w_nx < w_nxt.hs_end)) ?
                             w_nxt.hs_pol : ~w_nxt.hs_pol;
            r_vsync       <= ((w_ny >= w_nxt.vs_sta) && (w_ny < w_nxt.vs_end)) ?
                             w_nxt.vs_pol : ~w_nxt.vs_pol;
            r_frame_start <= w_frame_next;
            r_line_start  <= w_last_x;
            r_line_irq    <= w_last_x && (w_ny == irq_line);
            if (w_frame_next) begin
                r_started <= 1'b1;
                if (r_started) begin
                    r_frame_cnt <= r_frame_cnt + FRAMEW'(1);
                end
            end
        end
    end

    assign sx          = r_sx;
    assign sy          = r_sy;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign line_irq    = r_line_irq;
    assign frame_cnt   = r_frame_cnt;

endmodule
